// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_prog
//  Description : Programmable integer clock divider (N = 2..2^CNT_W-1) with
//                phase count, rising-edge tick and glitch-free runtime ratio
//                reprogramming at the period boundary.
//                Optional macro CLKDIV_ODD50_EN adds a negedge flop that
//                trims the high time of odd ratios to an exact 50% duty.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
  parameter int CNT_W       = 4,
  parameter int DIV_DEFAULT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic             load,
  output logic             busy,
  output logic             clk_out,
  output logic [CNT_W-1:0] phase,
  output logic             tick
);

  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_RESET = CNT_W'(DIV_DEFAULT);

  logic [CNT_W-1:0] ratio;        // active divide ratio
  logic [CNT_W-1:0] pending;      // ratio waiting for the next boundary
  logic             idle;         // en was low on the previous posedge
  logic             clk_pos;      // posedge-registered divided clock

  logic [CNT_W-1:0] req_clamped;
  logic [CNT_W-1:0] ratio_nxt;
  logic [CNT_W-1:0] phase_nxt;
  logic [CNT_W-1:0] half_nxt;
  logic             wrap;
  logic             boundary;

  // Boundary detection and selection of the ratio that governs the next phase.
  // A restart after en was low counts as a boundary so a pending ratio lands
  // on a clean period start.
  always_comb begin
    req_clamped = (div_ratio < C_TWO) ? C_TWO : div_ratio;
    wrap        = (phase == (ratio - C_ONE));
    boundary    = en & (wrap | idle);
    ratio_nxt   = ratio;
    if (boundary) begin
      if (load)
        ratio_nxt = req_clamped;
      else if (busy)
        ratio_nxt = pending;
    end
    phase_nxt = wrap ? '0 : (phase + C_ONE);
    half_nxt  = ratio_nxt >> 1;
  end

  // Phase counter, divided clock and tick; all forced low while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      clk_pos <= 1'b0;
      tick    <= 1'b0;
      ratio   <= C_RESET;
      idle    <= 1'b0;
    end else if (en) begin
      phase   <= phase_nxt;
      clk_pos <= (phase_nxt >= half_nxt);
      tick    <= (phase_nxt == half_nxt);
      ratio   <= ratio_nxt;
      idle    <= 1'b0;
    end else begin
      phase   <= '0;
      clk_pos <= 1'b0;
      tick    <= 1'b0;
      idle    <= 1'b1;
    end
  end

  // Pending-ratio register: a load at a boundary is consumed directly,
  // otherwise it is held (last load wins) until the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      busy    <= 1'b0;
    end else if (boundary) begin
      busy    <= 1'b0;
    end else if (load) begin
      pending <= req_clamped;
      busy    <= 1'b1;
    end
  end

`ifdef CLKDIV_ODD50_EN
  logic clk_neg;

  // Half-cycle delayed copy; ANDing it in delays only the rising edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)
      clk_neg <= 1'b0;
    else
      clk_neg <= clk_pos;
  end

  // Odd ratios use the trimmed high time; even ratios pass straight through.
  assign clk_out = clk_pos & (ratio[0] ? clk_neg : 1'b1);
`else
  assign clk_out = clk_pos;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_prog
//  Description : Self-checking bench for clk_div_prog: vector table of
//                posedge-by-posedge expectations plus hand sequences for duty
//                measurement and asynchronous reset with a pending ratio.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] div_ratio;
  logic       load;
  logic       busy;
  logic       clk_out;
  logic [3:0] phase;
  logic       tick;

  int total_checks;
  int passed_checks;

  time t_rise;
  time t_fall;

  typedef struct {
    logic       en;
    logic       load;
    logic [3:0] div;
    logic [3:0] ph;
    logic       ck;
    logic       tk;
    logic       bz;
    logic [3:0] n;   // active ratio after the edge
  } vec_t;

  vec_t vecs[$];

  clk_div_prog #(
    .CNT_W      (4),
    .DIV_DEFAULT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_ratio(div_ratio),
    .load     (load),
    .busy     (busy),
    .clk_out  (clk_out),
    .phase    (phase),
    .tick     (tick)
  );

  // 10 ns system clock, posedges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge timestamps of the divided clock for duty measurement.
  always @(posedge clk_out) t_rise = $time;
  always @(negedge clk_out) t_fall = $time;

  function automatic vec_t mk(input logic e, input logic l, input logic [3:0] d,
                              input logic [3:0] p, input logic c, input logic t,
                              input logic b, input logic [3:0] n);
    vec_t v;
    v.en = e; v.load = l; v.div = d; v.ph = p; v.ck = c; v.tk = t; v.bz = b; v.n = n;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total_checks++;
    if (act == exp)
      passed_checks++;
    else
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic step(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic prev_pos;
    logic exp_ck;
    int   guard;
    total_checks  = 0;
    passed_checks = 0;
    t_rise = 0;
    t_fall = 0;
    prev_pos = 1'b0;

    // en, load, div  ->  phase, clk_out, tick, busy, active N
    // Default N=4, two full periods
    for (int r = 0; r < 2; r++) begin
      vecs.push_back(mk(1,0,0, 1,0,0,0, 4));
      vecs.push_back(mk(1,0,0, 2,1,1,0, 4));
      vecs.push_back(mk(1,0,0, 3,1,0,0, 4));
      vecs.push_back(mk(1,0,0, 0,0,0,0, 4));
    end
    // Load 6 at phase 1: old period completes, then 3 low / 3 high
    vecs.push_back(mk(1,0,0, 1,0,0,0, 4));
    vecs.push_back(mk(1,1,6, 2,1,1,1, 4));
    vecs.push_back(mk(1,0,0, 3,1,0,1, 4));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 6));
    vecs.push_back(mk(1,0,0, 1,0,0,0, 6));
    vecs.push_back(mk(1,0,0, 2,0,0,0, 6));
    vecs.push_back(mk(1,0,0, 3,1,1,0, 6));
    vecs.push_back(mk(1,0,0, 4,1,0,0, 6));
    vecs.push_back(mk(1,0,0, 5,1,0,0, 6));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 6));
    // Load 1 -> clamped to 2 at the wrap
    vecs.push_back(mk(1,1,1, 1,0,0,1, 6));
    vecs.push_back(mk(1,0,0, 2,0,0,1, 6));
    vecs.push_back(mk(1,0,0, 3,1,1,1, 6));
    vecs.push_back(mk(1,0,0, 4,1,0,1, 6));
    vecs.push_back(mk(1,0,0, 5,1,0,1, 6));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 2));
    vecs.push_back(mk(1,0,0, 1,1,1,0, 2));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 2));
    vecs.push_back(mk(1,0,0, 1,1,1,0, 2));
    // Load 0 in the wrap cycle: applied directly as 2, busy stays 0
    vecs.push_back(mk(1,1,0, 0,0,0,0, 2));
    vecs.push_back(mk(1,0,0, 1,1,1,0, 2));
    // Load 5 in the wrap cycle: 2 low / 3 high from phase 0
    vecs.push_back(mk(1,1,5, 0,0,0,0, 5));
    vecs.push_back(mk(1,0,0, 1,0,0,0, 5));
    vecs.push_back(mk(1,0,0, 2,1,1,0, 5));
    vecs.push_back(mk(1,0,0, 3,1,0,0, 5));
    vecs.push_back(mk(1,0,0, 4,1,0,0, 5));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 5));
    // Load 0 mid-period -> pending 2
    vecs.push_back(mk(1,1,0, 1,0,0,1, 5));
    vecs.push_back(mk(1,0,0, 2,1,1,1, 5));
    vecs.push_back(mk(1,0,0, 3,1,0,1, 5));
    vecs.push_back(mk(1,0,0, 4,1,0,1, 5));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 2));
    vecs.push_back(mk(1,0,0, 1,1,1,0, 2));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 2));
    // Back to N=6, drop en at phase 2, re-enable: first tick after 3 cycles
    vecs.push_back(mk(1,1,6, 1,1,1,1, 2));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 6));
    vecs.push_back(mk(1,0,0, 1,0,0,0, 6));
    vecs.push_back(mk(1,0,0, 2,0,0,0, 6));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 6));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 6));
    vecs.push_back(mk(1,0,0, 1,0,0,0, 6));
    vecs.push_back(mk(1,0,0, 2,0,0,0, 6));
    vecs.push_back(mk(1,0,0, 3,1,1,0, 6));
    // Load while disabled: busy held, applied on the first enabled edge
    vecs.push_back(mk(0,0,0, 0,0,0,0, 6));
    vecs.push_back(mk(0,1,3, 0,0,0,1, 6));
    vecs.push_back(mk(1,0,0, 1,1,1,0, 3));
    vecs.push_back(mk(1,0,0, 2,1,0,0, 3));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 3));
    vecs.push_back(mk(1,0,0, 1,1,1,0, 3));

    // Reset state
    rst_n = 1'b0; en = 1'b0; load = 1'b0; div_ratio = 4'd0;
    #12;
    chk("reset_state", {phase, clk_out, tick, busy}, 7'd0);
    rst_n = 1'b1;

    // Table-driven run
    for (int i = 0; i < vecs.size(); i++) begin
      en        = vecs[i].en;
      load      = vecs[i].load;
      div_ratio = vecs[i].div;
      @(posedge clk);
      #1;
      exp_ck = vecs[i].ck;
`ifdef CLKDIV_ODD50_EN
      if (vecs[i].n[0])
        exp_ck = vecs[i].ck & prev_pos;
`endif
      prev_pos = vecs[i].ck;
      chk($sformatf("vec%0d{phase,clk_out,tick,busy}", i),
          {phase, clk_out, tick, busy},
          {vecs[i].ph, exp_ck, vecs[i].tk, vecs[i].bz});
    end
    load = 1'b0;

    // N=5 duty: edge-to-edge high time of clk_out (state is N=3, phase 1)
    load = 1'b1; div_ratio = 4'd5;
    step(1);
    load = 1'b0;
    chk("n5_pending_busy", busy, 1);
    step(1);
    chk("n5_applied_at_wrap", {phase, busy}, 5'd0);
    step(7);
    guard = 0;
    while (phase != 4'd1 && guard < 10) begin
      step(1);
      guard++;
    end
    chk("n5_sync_guard", (guard < 10) ? 1 : 0, 1);
`ifdef CLKDIV_ODD50_EN
    chk("n5_high_time_ns", int'(t_fall - t_rise), 25);
`else
    chk("n5_high_time_ns", int'(t_fall - t_rise), 30);
`endif

    // Asynchronous reset mid-period with a ratio pending
    step(1);
    load = 1'b1; div_ratio = 4'd6;
    step(1);
    load = 1'b0;
    chk("rst_pending_busy", busy, 1);
    step(1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {phase, clk_out, tick, busy}, 7'd0);
    #2;
    rst_n = 1'b1;
    step(2);
    chk("rst_restart_n4_phase2", {phase, clk_out, tick}, {4'd2, 1'b1, 1'b1});
    step(2);
    chk("rst_restart_n4_wrap", {phase, clk_out, busy}, 6'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
`default_nettype wire
